// File: rtl/pong_pkg.sv
// Shared widths and encodings for the pong ball engine and its helpers.
package pong_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned COORD_W = 10;  // pixel coordinate
  localparam int unsigned NXT_W   = 11;  // next-position arithmetic
  localparam int unsigned EDGE_W  = 12;  // signed edge arithmetic with headroom
  localparam int unsigned SPEED_W = 3;   // pixels per tick, 1..7

  // game_state input encodings
  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_RUN   = 2'b01;
  localparam logic [1:0] GS_PAUSE = 2'b10;

  // ball FSM states
  localparam logic [1:0] ST_SERVE = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  // winner encodings
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/ball_axis.sv
// Single-axis ball motion: steps the centre by speed, reports the next edges
// and applies a reflection against the low or high bound when requested.
module ball_axis
  import pong_pkg::*;
#(
  parameter int unsigned HALF = 8
) (
  input  logic                     [COORD_W-1:0] pos,
  input  logic                                   dir,
  input  logic                     [SPEED_W-1:0] speed,
  input  logic                     [COORD_W-1:0] lo_bound,
  input  logic                     [COORD_W-1:0] hi_bound,
  input  logic                                   bounce_lo,
  input  logic                                   bounce_hi,
  output logic                     [COORD_W-1:0] pos_next,
  output logic                                   dir_next,
  output logic signed              [EDGE_W-1:0]  lo_edge,
  output logic signed              [EDGE_W-1:0]  hi_edge
);

  localparam logic signed [EDGE_W-1:0] HALF_E = EDGE_W'(HALF);

  logic [NXT_W-1:0] sum;

  // Unclamped next centre (dir=1 is increasing) and the resulting ball edges
  always_comb begin
    if (dir) sum = {1'b0, pos} + NXT_W'(speed);
    else     sum = {1'b0, pos} - NXT_W'(speed);
    lo_edge = $signed({sum[NXT_W-1], sum}) - HALF_E;
    hi_edge = $signed({sum[NXT_W-1], sum}) + HALF_E;
  end

  // Reflection parks the ball flush against the bound and turns it around
  always_comb begin
    pos_next = sum[COORD_W-1:0];
    dir_next = dir;
    if (bounce_lo) begin
      pos_next = lo_bound + COORD_W'(HALF);
      dir_next = 1'b1;
    end else if (bounce_hi) begin
      pos_next = hi_bound - COORD_W'(HALF);
      dir_next = 1'b0;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball controller: serve timing, motion, wall/paddle bounces, scoring,
// win detection and the ball pixel mask.
module ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned BALL_SIZE   = 16,
  parameter int unsigned PADDLE_W    = 16,
  parameter int unsigned PADDLE_H    = 80,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned SERVE_TICKS = 500,
  parameter logic [11:0] BALL_RGB    = 12'h0FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               new_game,
  input  logic [1:0]         game_state,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x_paddle1,
  input  logic [COORD_W-1:0] y_paddle1,
  input  logic [COORD_W-1:0] x_paddle2,
  input  logic [COORD_W-1:0] y_paddle2,
  output logic               ball_on,
  output logic [11:0]        rgb_ball,
  output logic [COORD_W-1:0] x_ball,
  output logic [COORD_W-1:0] y_ball,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner
);

  localparam int unsigned HB    = BALL_SIZE / 2;
  localparam int unsigned HP    = PADDLE_W / 2;
  localparam int unsigned CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [COORD_W-1:0]       X_CTR   = COORD_W'(H_ACTIVE / 2);
  localparam logic [COORD_W-1:0]       Y_CTR   = COORD_W'(V_ACTIVE / 2);
  localparam logic signed [EDGE_W-1:0] H_EDGE  = EDGE_W'(H_ACTIVE);
  localparam logic signed [EDGE_W-1:0] V_EDGE  = EDGE_W'(V_ACTIVE);
  localparam logic signed [EDGE_W-1:0] HB_E    = EDGE_W'(HB);
  localparam logic signed [EDGE_W-1:0] REACH_E = EDGE_W'((PADDLE_H + BALL_SIZE) / 2);
  localparam logic signed [EDGE_W-1:0] ZERO_E  = '0;

  logic [1:0]         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SPEED_W-1:0] speed, speed_n;
  logic               dx, dx_n, dy, dy_n;
  logic [COORD_W-1:0] x_n, y_n;
  logic [SCORE_W-1:0] p1_n, p2_n, p1_inc, p2_inc;
  logic [1:0]         winner_n;

  logic [COORD_W-1:0]       x_lo_bound, x_hi_bound, x_pos_nx, y_pos_nx;
  logic                     x_dir_nx, y_dir_nx;
  logic signed [EDGE_W-1:0] x_lo_edge, x_hi_edge, y_lo_edge, y_hi_edge;
  logic signed [EDGE_W-1:0] d1, d2, a1, a2, xs, ys, xb, yb;
  logic                     p1_hit, p2_hit, miss_l, miss_r, wall_top, wall_bot, run;

  assign rgb_ball   = BALL_RGB;
  assign x_lo_bound = x_paddle1 + COORD_W'(HP);
  assign x_hi_bound = x_paddle2 - COORD_W'(HP);
  assign run        = tick && (game_state == GS_RUN);
  assign p1_inc     = p1_score + SCORE_W'(1);
  assign p2_inc     = p2_score + SCORE_W'(1);

  ball_axis #(.HALF(HB)) u_axis_x (
    .pos(x_ball), .dir(dx), .speed(speed),
    .lo_bound(x_lo_bound), .hi_bound(x_hi_bound),
    .bounce_lo(p1_hit), .bounce_hi(p2_hit),
    .pos_next(x_pos_nx), .dir_next(x_dir_nx),
    .lo_edge(x_lo_edge), .hi_edge(x_hi_edge)
  );

  ball_axis #(.HALF(HB)) u_axis_y (
    .pos(y_ball), .dir(dy), .speed(speed),
    .lo_bound('0), .hi_bound(COORD_W'(V_ACTIVE)),
    .bounce_lo(wall_top), .bounce_hi(wall_bot),
    .pos_next(y_pos_nx), .dir_next(y_dir_nx),
    .lo_edge(y_lo_edge), .hi_edge(y_hi_edge)
  );

  // Collision and scoring qualifiers; paddle hits only count toward the paddle
  always_comb begin
    d1       = $signed({2'b00, y_ball}) - $signed({2'b00, y_paddle1});
    d2       = $signed({2'b00, y_ball}) - $signed({2'b00, y_paddle2});
    a1       = d1[EDGE_W-1] ? -d1 : d1;
    a2       = d2[EDGE_W-1] ? -d2 : d2;
    p1_hit   = !dx && (x_lo_edge <= $signed({2'b00, x_lo_bound}))
               && (x_ball >= x_paddle1) && (a1 < REACH_E);
    p2_hit   = dx && (x_hi_edge >= $signed({2'b00, x_hi_bound}))
               && (x_ball <= x_paddle2) && (a2 < REACH_E);
    miss_l   = !p1_hit && !p2_hit && x_lo_edge[EDGE_W-1];
    miss_r   = !p1_hit && !p2_hit && (x_hi_edge >= H_EDGE);
    wall_top = y_lo_edge <= ZERO_E;
    wall_bot = y_hi_edge >= V_EDGE;
  end

  // Next-state and datapath update for one enabled tick
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    speed_n  = speed;
    dx_n     = dx;
    dy_n     = dy;
    x_n      = x_ball;
    y_n      = y_ball;
    p1_n     = p1_score;
    p2_n     = p2_score;
    winner_n = winner;
    if (new_game) begin
      state_n  = ST_SERVE;
      cnt_n    = '0;
      speed_n  = SPEED_W'(1);
      x_n      = X_CTR;
      y_n      = Y_CTR;
      p1_n     = '0;
      p2_n     = '0;
      winner_n = WIN_NONE;
    end else if (run) begin
      case (state)
        ST_SERVE: begin
          if (cnt == CNT_W'(SERVE_TICKS - 1)) begin
            state_n = ST_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          x_n  = x_pos_nx;
          dx_n = x_dir_nx;
          y_n  = y_pos_nx;
          dy_n = y_dir_nx;
          if (p1_hit || p2_hit) begin
            speed_n = (speed >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                     : speed + SPEED_W'(1);
          end else if (miss_l || miss_r) begin
            x_n     = X_CTR;
            y_n     = Y_CTR;
            speed_n = SPEED_W'(1);
            cnt_n   = '0;
            dx_n    = miss_r;
            state_n = ST_SERVE;
            if (miss_l) begin
              p2_n = p2_inc;
              if (p2_inc == SCORE_W'(WIN_SCORE)) begin
                state_n  = ST_OVER;
                winner_n = WIN_P2;
              end
            end else begin
              p1_n = p1_inc;
              if (p1_inc == SCORE_W'(WIN_SCORE)) begin
                state_n  = ST_OVER;
                winner_n = WIN_P1;
              end
            end
          end
        end
        ST_OVER: state_n = ST_OVER;
        default: state_n = ST_SERVE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SERVE;
      cnt      <= '0;
      speed    <= SPEED_W'(1);
      dx       <= 1'b1;
      dy       <= 1'b1;
      x_ball   <= X_CTR;
      y_ball   <= Y_CTR;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= WIN_NONE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      speed    <= speed_n;
      dx       <= dx_n;
      dy       <= dy_n;
      x_ball   <= x_n;
      y_ball   <= y_n;
      p1_score <= p1_n;
      p2_score <= p2_n;
      winner   <= winner_n;
    end
  end

  // Pixel mask: exactly BALL_SIZE pixels per axis, hidden once the game is over
  always_comb begin
    xs      = $signed({2'b00, x});
    ys      = $signed({2'b00, y});
    xb      = $signed({2'b00, x_ball});
    yb      = $signed({2'b00, y_ball});
    ball_on = (state != ST_OVER)
              && (xs >= xb - HB_E) && (xs < xb + HB_E)
              && (ys >= yb - HB_E) && (ys < yb + HB_E);
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: serve, walls, paddles, scoring, win, freeze, reset.
module tb_ball_engine;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       new_game = 1'b0;
  logic [1:0] game_state = GS_IDLE;
  logic [9:0] x = '0, y = '0;
  logic [9:0] x_paddle1 = 10'd20,  y_paddle1 = 10'd400;
  logic [9:0] x_paddle2 = 10'd600, y_paddle2 = 10'd100;
  logic       ball_on;
  logic [11:0] rgb_ball;
  logic [9:0] x_ball, y_ball;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  int vec_cnt = 0;
  int err_cnt = 0;

  ball_engine #(.SERVE_TICKS(5), .WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .new_game(new_game),
    .game_state(game_state), .x(x), .y(y),
    .x_paddle1(x_paddle1), .y_paddle1(y_paddle1),
    .x_paddle2(x_paddle2), .y_paddle2(y_paddle2),
    .ball_on(ball_on), .rgb_ball(rgb_ball), .x_ball(x_ball), .y_ball(y_ball),
    .p1_score(p1_score), .p2_score(p2_score), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(x_ball), 32'(ex));
    check({tag, ".y"}, 32'(y_ball), 32'(ey));
  endtask

  task automatic check_pix(input string tag, input int px, input int py, input logic exp);
    x = 10'(px);
    y = 10'(py);
    #1;
    check(tag, 32'(ball_on), 32'(exp));
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    game_state = GS_RUN;
    @(negedge clk);
    check_pos("reset", 320, 240);
    check("reset.p1", 32'(p1_score), 32'd0);
    check("reset.p2", 32'(p2_score), 32'd0);
    check("reset.winner", 32'(winner), 32'd0);
    check("rgb", 32'(rgb_ball), 32'h0FF);

    // serve holds for 5 ticks, first move on the 6th
    run_ticks(5);
    check_pos("serve_hold", 320, 240);
    run_ticks(1);
    check_pos("first_move", 321, 241);

    // freeze mid-play
    run_ticks(99);
    check_pos("pre_freeze", 420, 340);
    game_state = GS_PAUSE;
    run_ticks(20);
    check_pos("frozen", 420, 340);
    check("frozen.p1", 32'(p1_score), 32'd0);
    game_state = GS_RUN;

    // bottom wall at t=232, then right-side miss (paddle2 out of reach)
    run_ticks(211);
    check_pos("pre_miss_r", 631, 393);
    run_ticks(1);
    check("miss_r.p1", 32'(p1_score), 32'd1);
    check("miss_r.p2", 32'(p2_score), 32'd0);
    check_pos("miss_r.ctr", 320, 240);
    run_ticks(5);
    check_pos("reserve_hold", 320, 240);
    run_ticks(1);
    check_pos("reserve_dir", 321, 239);

    // asynchronous reset between clock edges
    run_ticks(10);
    reset = 1'b0;
    #1;
    check_pos("async_rst", 320, 240);
    check("async_rst.p1", 32'(p1_score), 32'd0);
    @(negedge clk) reset = 1'b1;

    // right paddle hit with direction qualifier
    y_paddle2 = 10'd440;
    run_ticks(5 + 263);
    check_pos("pre_hit2", 583, 441);
    run_ticks(1);
    check_pos("hit2", 584, 440);
    x_paddle2 = 10'd590;
    run_ticks(1);
    check_pos("no_reflip1", 582, 438);
    run_ticks(1);
    check_pos("no_reflip2", 580, 436);
    x_paddle2 = 10'd600;

    // top wall at speed 2
    run_ticks(213);
    check_pos("pre_top", 154, 10);
    run_ticks(1);
    check_pos("top_clamp", 152, 8);
    run_ticks(1);
    check_pos("top_away", 150, 10);

    // left-side miss gives p2 a point
    run_ticks(71);
    check_pos("pre_miss_l", 8, 152);
    run_ticks(1);
    check("miss_l.p2", 32'(p2_score), 32'd1);
    check_pos("miss_l.ctr", 320, 240);

    // second p2 point wins the game
    y_paddle1 = 10'd100;
    run_ticks(5 + 312);
    check_pos("pre_win", 8, 392);
    run_ticks(1);
    check("win.p2", 32'(p2_score), 32'd2);
    check("win.winner", 32'(winner), 32'd2);
    check_pos("win.ctr", 320, 240);
    check_pix("win.pix_ctr", 320, 240, 1'b0);
    check_pix("win.pix_corner", 312, 232, 1'b0);
    run_ticks(3);
    check("over.winner", 32'(winner), 32'd2);
    check_pos("over.held", 320, 240);

    // new game restarts from serve
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    check("ng.p1", 32'(p1_score), 32'd0);
    check("ng.p2", 32'(p2_score), 32'd0);
    check("ng.winner", 32'(winner), 32'd0);
    check_pix("pix_ctr", 320, 240, 1'b1);
    check_pix("pix_tl", 312, 232, 1'b1);
    check_pix("pix_left_out", 311, 240, 1'b0);
    check_pix("pix_br", 327, 247, 1'b1);
    check_pix("pix_right_out", 328, 240, 1'b0);
    check_pix("pix_bottom_out", 320, 248, 1'b0);

    // left paddle hit after top-wall bounce
    y_paddle1 = 10'd60;
    run_ticks(5 + 283);
    check_pos("pre_hit1", 37, 59);
    run_ticks(1);
    check_pos("hit1", 36, 60);
    run_ticks(1);
    check_pos("post_hit1", 38, 62);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
